// File: rtl/prng_word_buffer.sv
// Collects four bytes per get_random request from the byte-serial PRNG, packs them
// LSB-first into 32-bit words and serves them from a small FWFT FIFO over valid/ready.
module prng_word_buffer #(
    parameter int  DEPTH   = 4,
    parameter int  TIMEOUT = 16,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    output logic          rnd_req,
    input  logic [7:0]    rnd_byte,
    input  logic          rnd_byte_vld,
    output logic [31:0]   word_data,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [LW-1:0] fill_level,
    input  logic          err_clr,
    output logic          err_stray,
    output logic          err_timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t        state_q;
    logic          rnd_req_q;
    logic [1:0]    lane_q;
    logic [TW-1:0] tcnt_q;
    logic [31:0]   asm_q;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] fill_q, fill_d;
    logic          err_stray_q, err_stray_d;
    logic          err_timeout_q, err_timeout_d;

    logic push, pop, stray_evt, timeout_evt;

    assign push        = (state_q == S_PUSH);
    assign pop         = (fill_q != '0) && word_ready;
    assign stray_evt   = rnd_byte_vld && (state_q != S_WAIT);
    assign timeout_evt = (state_q == S_WAIT) && !rnd_byte_vld && (tcnt_q == TW'(TIMEOUT - 1));

    // Request only when a slot is free, so the single in-flight word can never overflow.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= S_IDLE;
            rnd_req_q <= 1'b0;
            lane_q    <= '0;
            tcnt_q    <= '0;
            asm_q     <= '0;
        end else begin
            rnd_req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable && (fill_q < LW'(DEPTH))) begin
                        state_q   <= S_REQ;
                        rnd_req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    lane_q  <= '0;
                    tcnt_q  <= '0;
                    asm_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (rnd_byte_vld) begin
                        asm_q[{lane_q, 3'b000} +: 8] <= rnd_byte;
                        lane_q <= lane_q + 2'd1;
                        tcnt_q <= '0;
                        if (lane_q == 2'd3) begin
                            state_q <= S_PUSH;
                        end
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_PUSH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + LW'(1);
            2'b01:   fill_d = fill_q - LW'(1);
            default: fill_d = fill_q;
        endcase
        // A set event in the same cycle wins over the clear.
        err_stray_d   = stray_evt   ? 1'b1 : (err_clr ? 1'b0 : err_stray_q);
        err_timeout_d = timeout_evt ? 1'b1 : (err_clr ? 1'b0 : err_timeout_q);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            err_stray_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            err_stray_q   <= err_stray_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= asm_q;
        end
    end

    assign rnd_req     = rnd_req_q;
    assign word_valid  = (fill_q != '0);
    assign word_data   = (fill_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fill_level  = fill_q;
    assign err_stray   = err_stray_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_prng_word_buffer.sv
// Directed bench for prng_word_buffer: a byte-generator model answers each request two
// cycles later; popped words are checked in order against hand-computed expectations.
module tb_prng_word_buffer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          rnd_req;
    logic [7:0]    rnd_byte;
    logic          rnd_byte_vld;
    logic [31:0]   word_data;
    logic          word_valid;
    logic          word_ready;
    logic [LW-1:0] fill_level;
    logic          err_clr;
    logic          err_stray;
    logic          err_timeout;

    prng_word_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rstn         (rst),
        .enable       (enable),
        .rnd_req      (rnd_req),
        .rnd_byte     (rnd_byte),
        .rnd_byte_vld (rnd_byte_vld),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .fill_level   (fill_level),
        .err_clr      (err_clr),
        .err_stray    (err_stray),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] exp_q [$];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          req_cnt = 0;
    bit          chk_le1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pop check happens before the edge that performs the pop.
    task automatic tick();
        if (word_valid === 1'b1 && word_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_unexpected: got %h, expected no word", word_data);
            end else begin
                chk("pop_order", word_data, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (rnd_req === 1'b1) req_cnt++;
        if (chk_le1) chk("fill_le1", 32'(fill_level <= LW'(1)), 32'd1);
    endtask

    task automatic gen_word(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int nb);
        logic [7:0] bs [4];
        bit found;
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rnd_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_wait: got no rnd_req, expected one within 40 cycles");
        end else begin
            tick();
            tick();
            for (int i = 0; i < nb; i++) begin
                rnd_byte     = bs[i];
                rnd_byte_vld = 1'b1;
                tick();
            end
            rnd_byte_vld = 1'b0;
            rnd_byte     = 8'h00;
        end
    endtask

    task automatic drain();
        word_ready = 1'b1;
        for (int i = 0; i < 20 && word_valid === 1'b1; i++) tick();
        word_ready = 1'b0;
        chk("drain_fill", 32'(fill_level), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hCD, 8'h8A, 8'h46, 8'h02, 32'h02468ACD};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
        vecs[3] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        vecs[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF};
        vecs[5] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 32'hFE7F8001};

        rst = 1'b1; enable = 1'b0; rnd_byte = 8'h00; rnd_byte_vld = 1'b0;
        word_ready = 1'b0; err_clr = 1'b0;

        // Reset and idle
        repeat (3) tick();
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_rnd_req", 32'(rnd_req), 32'd0);
        rst = 1'b0;
        req_cnt = 0;
        repeat (20) tick();
        chk("idle_req_cnt", 32'(req_cnt), 32'd0);
        chk("idle_word_data", word_data, 32'd0);
        chk("idle_word_valid", 32'(word_valid), 32'd0);
        chk("idle_fill", 32'(fill_level), 32'd0);
        chk("idle_errs", {30'd0, err_stray, err_timeout}, 32'd0);

        // Single word
        enable = 1'b1;
        exp_q.push_back(vecs[0].exp);
        gen_word(vecs[0].b0, vecs[0].b1, vecs[0].b2, vecs[0].b3, 4);
        tick();
        chk("single_data", word_data, 32'h02468ACD);
        chk("single_valid", 32'(word_valid), 32'd1);
        chk("single_fill", 32'(fill_level), 32'd1);
        chk("single_req_cnt", 32'(req_cnt), 32'd1);

        // Fill and hold
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(vecs[k].exp);
            gen_word(vecs[k].b0, vecs[k].b1, vecs[k].b2, vecs[k].b3, 4);
            tick();
            chk("fill_step", 32'(fill_level), 32'(k + 1));
        end
        repeat (20) tick();
        chk("full_req_cnt", 32'(req_cnt), 32'd4);
        chk("full_fill", 32'(fill_level), 32'd4);
        chk("full_head", word_data, 32'h02468ACD);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("pop_one_fill", 32'(fill_level), 32'd3);
        exp_q.push_back(vecs[4].exp);
        gen_word(vecs[4].b0, vecs[4].b1, vecs[4].b2, vecs[4].b3, 4);
        tick();
        chk("refill_fill", 32'(fill_level), 32'd4);
        chk("refill_req_cnt", 32'(req_cnt), 32'd5);
        enable = 1'b0;
        drain();

        // Simultaneous push/pop, table-driven
        word_ready = 1'b1;
        enable     = 1'b1;
        req_cnt    = 0;
        chk_le1    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            gen_word(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, 4);
            if (i == 5) enable = 1'b0;
            tick();
            chk("vec_data", word_data, vecs[i].exp);
            chk("vec_valid", 32'(word_valid), 32'd1);
        end
        tick();
        chk_le1 = 1'b0;
        chk("stream_queue", 32'(exp_q.size()), 32'd0);
        chk("stream_fill", 32'(fill_level), 32'd0);
        chk("stream_req_cnt", 32'(req_cnt), 32'd6);
        word_ready = 1'b0;

        // Timeout after two bytes
        enable = 1'b1;
        gen_word(8'hAA, 8'hBB, 8'h00, 8'h00, 2);
        repeat (TIMEOUT - 1) tick();
        chk("timeout_early", 32'(err_timeout), 32'd0);
        tick();
        chk("timeout_set", 32'(err_timeout), 32'd1);
        chk("timeout_fill", 32'(fill_level), 32'd0);
        exp_q.push_back(32'h78563412);
        gen_word(8'h12, 8'h34, 8'h56, 8'h78, 4);
        enable = 1'b0;
        tick();
        chk("after_timeout_data", word_data, 32'h78563412);
        chk("timeout_sticky", 32'(err_timeout), 32'd1);
        drain();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("timeout_clr", 32'(err_timeout), 32'd0);

        // Stray byte and clear priority
        chk("stray_pre", 32'(err_stray), 32'd0);
        rnd_byte = 8'h5A; rnd_byte_vld = 1'b1;
        tick();
        rnd_byte_vld = 1'b0;
        chk("stray_set", 32'(err_stray), 32'd1);
        chk("stray_fill", 32'(fill_level), 32'd0);
        chk("stray_no_timeout", 32'(err_timeout), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("stray_clr", 32'(err_stray), 32'd0);
        err_clr = 1'b1; rnd_byte_vld = 1'b1;
        tick();
        err_clr = 1'b0; rnd_byte_vld = 1'b0;
        chk("stray_set_wins", 32'(err_stray), 32'd1);

        // Reset mid-collection discards the partial word
        enable = 1'b1;
        gen_word(8'h99, 8'h88, 8'h00, 8'h00, 2);
        rst = 1'b1;
        #1;
        chk("midrst_fill", 32'(fill_level), 32'd0);
        chk("midrst_err", 32'(err_stray), 32'd0);
        chk("midrst_req", 32'(rnd_req), 32'd0);
        tick();
        rst = 1'b0;
        exp_q.push_back(32'hCAFEF00D);
        gen_word(8'h0D, 8'hF0, 8'hFE, 8'hCA, 4);
        enable = 1'b0;
        tick();
        chk("midrst_next_word", word_data, 32'hCAFEF00D);
        chk("midrst_next_fill", 32'(fill_level), 32'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_word_buffer.md
Name: prng_word_buffer

Overview:
- Downstream consumer of the byte-serial PRNG stage.
- Issues one-cycle get_random requests, collects the four bytes the generator emits per request, and assembles them LSB-first into 32-bit words.
- Buffers the words in a small first-word-fall-through (FWFT) FIFO and serves them to consumers over a valid/ready handshake.
- Keeps the FIFO topped up autonomously while enabled and flags protocol faults (stray bytes, stalled generator).

Parameters:
DEPTH, 4, FIFO depth in 32-bit words; power of two, >= 2
TIMEOUT, 16, max cycles allowed between request and first byte, or between consecutive bytes; >= 2
LW, $clog2(DEPTH)+1, width of fill_level (derived, not overridable)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous, active-high reset (1 = reset asserted)
enable  input  1  1 = keep FIFO refilled; 0 = issue no new requests
rnd_req  output  1  one-cycle request pulse; drives generator get_random
rnd_byte  input  8  byte from generator
rnd_byte_vld  input  1  rnd_byte valid this cycle; high while generator is in its data-out state
word_data  output  32  head-of-FIFO word; 0 when FIFO empty
word_valid  output  1  FIFO not empty
word_ready  input  1  consumer accepts word_data this cycle
fill_level  output  LW  words currently stored, 0..DEPTH
err_clr  input  1  clears both sticky error flags
err_stray  output  1  sticky: byte arrived while not collecting
err_timeout  output  1  sticky: collection aborted by timeout

Behaviour:
- Reset (rstn=1, async): FSM to IDLE; pointers, fill_level, byte lane counter, timeout counter, assembly register all 0. Outputs: rnd_req=0, word_valid=0, word_data=0, fill_level=0, err_stray=0, err_timeout=0. Reset mid-collection discards the partial word.
- FSM states:
  - IDLE: if enable && fill_level<DEPTH, go to REQ; else stay.
  - REQ: rnd_req=1 for exactly this cycle; clear lane counter and timeout counter; go to WAIT.
  - WAIT: on each rnd_byte_vld, write rnd_byte to lane[cnt] (bits cnt*8+7:cnt*8), cnt++, reset timeout counter. The 4th byte (cnt==3) goes to PUSH. Without a byte, timeout counter++; at TIMEOUT-1 go to IDLE, set err_timeout, discard partial word.
  - PUSH: write the assembled word into the FIFO at wr_ptr; go to IDLE.
- Byte order: first byte received -> word_data[7:0], fourth -> [31:24].
- No overflow by construction: only one word is ever in flight, and a request is issued only when fill_level<DEPTH.
- Lowering enable never aborts a collection; the current word completes and is pushed.
- FIFO:
  - Circular, FWFT. word_valid = (fill_level!=0). word_data = mem[rd_ptr] when valid, else 0.
  - Pop when word_valid && word_ready; rd_ptr wraps DEPTH-1 -> 0. word_ready is ignored when empty.
  - Push and pop in the same cycle: fill_level unchanged, both pointers advance.
  - A pushed word is visible on word_data the cycle after PUSH.
- Stray byte: rnd_byte_vld in any state other than WAIT sets err_stray; the byte is ignored.
- Error flags: err_clr clears both flags; a set event in the same cycle has priority over clear.
- Latency: from enable rising with FIFO empty to word_valid = 1 (REQ) + generator latency + 4 byte cycles + 1 (PUSH) + 1.
- Throughput: one word per request round trip; refill continues back-to-back until fill_level==DEPTH.

Test Plan:
- Reset/idle: hold rstn=1, then release with enable=0 for 20 cycles -> all outputs 0, no rnd_req.
- Single word: enable=1; model answers rnd_req after 2 cycles with bytes 0xCD,0x8A,0x46,0x02 -> exactly one rnd_req per word, word_data=0x02468ACD, fill_level increments.
- Fill and hold: word_ready=0, enable=1 -> exactly DEPTH=4 requests, fill_level=4, then no further rnd_req. Pop one word -> one new request, fill_level returns to 4.
- Simultaneous push/pop: word_ready=1 continuously with the generator model answering -> words in generation order, no loss or duplication, fill_level never exceeds 1 after the first push.
- Timeout: model answers only 2 bytes then stops -> after TIMEOUT=16 idle cycles err_timeout=1, partial word discarded, new rnd_req issued, next full word correct.
- Stray byte and clear: pulse rnd_byte_vld in IDLE -> err_stray=1, FIFO unchanged. Assert err_clr -> 0. Assert err_clr together with a new stray byte -> err_stray stays 1.
